window_gen_3x3: RTL and testbench

WINDOW_GEN_3X3 -- requirements
Module: window_gen_3x3

---
 rtl/fusion_pkg.sv | 17 +
 rtl/window_gen_3x3_if.sv | 26 ++
 rtl/linebuf_ram.sv | 27 ++
 rtl/window_gen_3x3_core.sv | 157 +++++++++++++++
 rtl/window_gen_3x3.sv | 49 ++++
 tb/tb_window_gen_3x3.sv | 362 ++++++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/fusion_pkg.sv
// fusion_pkg: shared state type and constants for the 3x3 window generator.
// Used by window_gen_3x3 and its sub-blocks.
package fusion_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } wg_state_e;

  localparam int TAP_NUM    = 9;
  localparam int TAP_FIRST  = 0;
  localparam int TAP_CENTER = 4;
  localparam int TAP_LAST   = 8;
  localparam int WINGEN_LAT = 2;

endpackage

// File: rtl/window_gen_3x3_if.sv
// window_gen_3x3_if: pixel stream in, 3x3 window stream out.
// master drives pixels, slave produces windows.
interface window_gen_3x3_if
  import fusion_pkg::*;
#(
  parameter int DATAWIDTH = 8
);

  logic                           isync;
  logic                           ivalid;
  logic [DATAWIDTH-1:0]           idata;
  logic                           osync;
  logic                           ovalid;
  logic [TAP_NUM*DATAWIDTH-1:0]   odata;

  modport master (
    output isync, ivalid, idata,
    input  osync, ovalid, odata
  );

  modport slave (
    input  isync, ivalid, idata,
    output osync, ovalid, odata
  );

endinterface

// File: rtl/linebuf_ram.sv
// linebuf_ram: simple dual-port line store, registered read.
// Contents are never reset; the fill phase rewrites them before use.
module linebuf_ram #(
  parameter int DATAWIDTH = 8,
  parameter int DEPTH     = 2048,
  parameter int ADDR_W    = 11
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [ADDR_W-1:0]    waddr_i,
  input  logic [DATAWIDTH-1:0] wdata_i,
  input  logic                 re_i,
  input  logic [ADDR_W-1:0]    raddr_i,
  output logic [DATAWIDTH-1:0] rdata_o
);

  logic [DATAWIDTH-1:0] mem_q [DEPTH];
  logic [DATAWIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/window_gen_3x3_core.sv
// window_gen_3x3_core: frame FSM, two line stores and the 3x3 tap array.
// Optional sticky framing error output err_o under WINGEN_LINE_ERR_EN.
module window_gen_3x3_core
  import fusion_pkg::*;
#(
  parameter int DATAWIDTH = 8,
  parameter int MAX_WIDTH = 2048,
  parameter int ADDR_W    = 11
) (
  input  logic              iclk,
  input  logic              reset_an_i,
  input  logic [ADDR_W:0]   cfg_width,
  input  logic [11:0]       cfg_height,
`ifdef WINGEN_LINE_ERR_EN
  output logic              err_o,
`endif
  window_gen_3x3_if.slave   bus
);

  wg_state_e            state_q, state_d, cur;
  logic [ADDR_W-1:0]    col_q, col_d, col, col1_q;
  logic [11:0]          row_q, row_d, row;
  logic [ADDR_W:0]      wid_q, wid;
  logic [11:0]          hgt_q, hgt;
  logic                 acc, last_col, elig;
  logic                 acc1_q, elig1_q;
  logic                 sync1_q, osync_q, ovalid_q;
  logic [DATAWIDTH-1:0] pix1_q, ram0_rd, ram1_rd;
  logic [TAP_NUM-1:0][DATAWIDTH-1:0] win_q;

  // isync restarts the frame in the same cycle it arrives
  always_comb begin
    col = bus.isync ? '0 : col_q;
    row = bus.isync ? '0 : row_q;
    wid = bus.isync ? cfg_width : wid_q;
    hgt = bus.isync ? cfg_height : hgt_q;
  end

  assign acc      = bus.ivalid & (bus.isync | (state_q != IDLE));
  assign last_col = ({1'b0, col} == wid - (ADDR_W+1)'(1));
  assign elig     = acc & (row >= 12'd2) & (col >= ADDR_W'(2));

  always_comb begin
    cur     = bus.isync ? FILL : state_q;
    state_d = cur;
    col_d   = col;
    row_d   = row;
    if (acc) begin
      col_d = last_col ? '0 : col + ADDR_W'(1);
      row_d = last_col ? row + 12'd1 : row;
      if (last_col) begin
        unique case (cur)
          FILL:    if (row == 12'd1) state_d = RUN;
          RUN:     if (row == hgt - 12'd1) state_d = IDLE;
          default: state_d = cur;
        endcase
      end
    end
  end

  always_ff @(posedge iclk or negedge reset_an_i) begin
    if (!reset_an_i) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      wid_q   <= '0;
      hgt_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      wid_q   <= wid;
      hgt_q   <= hgt;
    end
  end

  linebuf_ram #(
    .DATAWIDTH (DATAWIDTH),
    .DEPTH     (MAX_WIDTH),
    .ADDR_W    (ADDR_W)
  ) u_ram0 (
    .clk_i   (iclk),
    .we_i    (acc),
    .waddr_i (col),
    .wdata_i (bus.idata),
    .re_i    (acc),
    .raddr_i (col),
    .rdata_o (ram0_rd)
  );

  // line r-1 moves down one cycle later, once its old value is read out
  linebuf_ram #(
    .DATAWIDTH (DATAWIDTH),
    .DEPTH     (MAX_WIDTH),
    .ADDR_W    (ADDR_W)
  ) u_ram1 (
    .clk_i   (iclk),
    .we_i    (acc1_q),
    .waddr_i (col1_q),
    .wdata_i (ram0_rd),
    .re_i    (acc),
    .raddr_i (col),
    .rdata_o (ram1_rd)
  );

  always_ff @(posedge iclk or negedge reset_an_i) begin
    if (!reset_an_i) begin
      acc1_q   <= 1'b0;
      elig1_q  <= 1'b0;
      col1_q   <= '0;
      pix1_q   <= '0;
      sync1_q  <= 1'b0;
      osync_q  <= 1'b0;
      ovalid_q <= 1'b0;
      win_q    <= '0;
    end else begin
      acc1_q   <= acc;
      elig1_q  <= elig;
      sync1_q  <= bus.isync;
      osync_q  <= sync1_q;
      ovalid_q <= acc1_q & elig1_q;
      if (acc) begin
        col1_q <= col;
        pix1_q <= bus.idata;
      end
      if (acc1_q) begin
        for (int i = 0; i < 3; i++) begin
          win_q[i*3]   <= win_q[i*3+1];
          win_q[i*3+1] <= win_q[i*3+2];
        end
        win_q[2] <= ram1_rd;
        win_q[5] <= ram0_rd;
        win_q[8] <= pix1_q;
      end
    end
  end

  assign bus.osync  = osync_q;
  assign bus.ovalid = ovalid_q;
  assign bus.odata  = win_q;

`ifdef WINGEN_LINE_ERR_EN
  logic err_q;

  always_ff @(posedge iclk or negedge reset_an_i) begin
    if (!reset_an_i) begin
      err_q <= 1'b0;
    end else if ((bus.ivalid & ~bus.isync & (state_q == IDLE)) |
                 (bus.isync & (state_q != IDLE))) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`endif

endmodule

// File: rtl/window_gen_3x3.sv
// window_gen_3x3: raster pixels in, 3x3 neighbourhood windows out.
// Define WINGEN_LINE_ERR_EN to add the sticky err_o framing flag.
module window_gen_3x3
  import fusion_pkg::*;
#(
  parameter int DATAWIDTH = 8,
  parameter int MAX_WIDTH = 2048,
  parameter int ADDR_W    = 11
) (
  input  logic                   iclk,
  input  logic                   reset_an_i,
  input  logic [ADDR_W:0]        cfg_width,
  input  logic [11:0]            cfg_height,
  input  logic                   isync,
  input  logic                   ivalid,
  input  logic [DATAWIDTH-1:0]   idata,
`ifdef WINGEN_LINE_ERR_EN
  output logic                   err_o,
`endif
  output logic                   osync,
  output logic                   ovalid,
  output logic [DATAWIDTH*9-1:0] odata
);

  window_gen_3x3_if #(.DATAWIDTH(DATAWIDTH)) bus ();

  assign bus.isync  = isync;
  assign bus.ivalid = ivalid;
  assign bus.idata  = idata;
  assign osync      = bus.osync;
  assign ovalid     = bus.ovalid;
  assign odata      = bus.odata;

  window_gen_3x3_core #(
    .DATAWIDTH (DATAWIDTH),
    .MAX_WIDTH (MAX_WIDTH),
    .ADDR_W    (ADDR_W)
  ) u_core (
    .iclk       (iclk),
    .reset_an_i (reset_an_i),
    .cfg_width  (cfg_width),
    .cfg_height (cfg_height),
`ifdef WINGEN_LINE_ERR_EN
    .err_o      (err_o),
`endif
    .bus        (bus)
  );

endmodule

// File: tb/tb_window_gen_3x3.sv
// tb_window_gen_3x3: directed frames with hand-derived expected windows.
// Optional err_o checks follow WINGEN_LINE_ERR_EN.
module tb_window_gen_3x3;
  import fusion_pkg::*;

  localparam int DW = 8;
  localparam int MW = 2048;
  localparam int AW = 11;
  localparam int BIG = 1 << 30;
  localparam logic [9*DW-1:0] FIRST =
    {8'd34, 8'd33, 8'd32, 8'd18, 8'd17, 8'd16, 8'd2, 8'd1, 8'd0};

  logic          iclk;
  logic          reset_an_i;
  logic [AW:0]   cfg_width;
  logic [11:0]   cfg_height;
`ifdef WINGEN_LINE_ERR_EN
  logic          err;
`endif

  window_gen_3x3_if #(.DATAWIDTH(DW)) bus ();

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [9*DW-1:0] win_q[$];
  logic [9*DW-1:0] exp_win[$];
  int win_cyc[$];
  int exp_cyc[$];
  int sync_cyc[$];
  int exp_sync[$];

  window_gen_3x3 #(
    .DATAWIDTH (DW),
    .MAX_WIDTH (MW),
    .ADDR_W    (AW)
  ) dut (
    .iclk       (iclk),
    .reset_an_i (reset_an_i),
    .cfg_width  (cfg_width),
    .cfg_height (cfg_height),
    .isync      (bus.isync),
    .ivalid     (bus.ivalid),
    .idata      (bus.idata),
`ifdef WINGEN_LINE_ERR_EN
    .err_o      (err),
`endif
    .osync      (bus.osync),
    .ovalid     (bus.ovalid),
    .odata      (bus.odata)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  always @(posedge iclk) cyc <= cyc + 1;

  always @(negedge iclk) begin
    if (bus.ovalid) begin
      win_q.push_back(bus.odata);
      win_cyc.push_back(cyc);
    end
    if (bus.osync) sync_cyc.push_back(cyc);
  end

  function automatic logic [DW-1:0] pix(input int r, input int c, input int off);
    return DW'(r * 16 + c + off);
  endfunction

  function automatic logic [9*DW-1:0] win_at(input int r, input int c, input int off);
    logic [9*DW-1:0] w;
    w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[(i*3+j)*DW +: DW] = pix(r - 2 + i, c - 2 + j, off);
    return w;
  endfunction

  task automatic clear_q();
    win_q.delete(); win_cyc.delete(); sync_cyc.delete();
    exp_win.delete(); exp_cyc.delete(); exp_sync.delete();
  endtask

  task automatic do_reset();
    reset_an_i = 1'b0;
    bus.isync = 1'b0; bus.ivalid = 1'b0; bus.idata = '0;
    cfg_width = '0; cfg_height = '0;
    repeat (2) @(negedge iclk);
    reset_an_i = 1'b1;
    @(negedge iclk);
    clear_q();
  endtask

  // drives pixels with linear index < stop; expected outputs at drive cycle + 2
  task automatic run_frame(input int w, input int h, input int off,
                           input int stop, input bit gap);
    int n;
    n = 0;
    cfg_width = w[AW:0];
    cfg_height = h[11:0];
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        if (n < stop) begin
          bus.isync = (n == 0);
          bus.ivalid = 1'b1;
          bus.idata = pix(r, c, off);
          if (n == 0) exp_sync.push_back(cyc + 2);
          if (r >= 2 && c >= 2) begin
            exp_win.push_back(win_at(r, c, off));
            exp_cyc.push_back(cyc + 2);
          end
          @(negedge iclk);
          if (gap) begin
            bus.isync = 1'b0; bus.ivalid = 1'b0; bus.idata = 8'hEE;
            @(negedge iclk);
          end
        end
        n++;
      end
    end
    bus.isync = 1'b0;
    bus.ivalid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.ovalid !== 1'b0) begin
      errors++; $display("FAIL rst_ovalid: got %b want 0", bus.ovalid);
    end
    checks++;
    if (bus.osync !== 1'b0) begin
      errors++; $display("FAIL rst_osync: got %b want 0", bus.osync);
    end
    checks++;
    if (bus.odata !== '0) begin
      errors++; $display("FAIL rst_odata: got %h want 0", bus.odata);
    end
    checks++;
    if (dut.u_core.state_q !== IDLE) begin
      errors++; $display("FAIL rst_state: got %0d want IDLE", dut.u_core.state_q);
    end
`ifdef WINGEN_LINE_ERR_EN
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL rst_err: got %b want 0", err);
    end
`endif
  endtask

  task automatic test_continuous();
    do_reset();
    run_frame(5, 4, 0, BIG, 1'b0);
    repeat (4) @(negedge iclk);
    checks++;
    if (win_q.size() != 6) begin
      errors++; $display("FAIL cont_count: got %0d want 6", win_q.size());
    end
    checks++;
    if (win_q.size() < 1 || win_q[0] !== FIRST) begin
      errors++; $display("FAIL cont_first: got %h want %h", win_q[0], FIRST);
    end
    for (int k = 0; k < exp_win.size(); k++) begin
      checks++;
      if (k >= win_q.size() || win_q[k] !== exp_win[k] || win_cyc[k] != exp_cyc[k]) begin
        errors++;
        $display("FAIL cont_win%0d: got %h @%0d want %h @%0d",
                 k, win_q[k], win_cyc[k], exp_win[k], exp_cyc[k]);
      end
    end
    checks++;
    if (sync_cyc.size() != 1 || sync_cyc[0] != exp_sync[0]) begin
      errors++; $display("FAIL cont_osync: got n=%0d @%0d want n=1 @%0d",
                         sync_cyc.size(), sync_cyc[0], exp_sync[0]);
    end
  endtask

  task automatic test_gap();
    do_reset();
    run_frame(5, 4, 0, BIG, 1'b1);
    repeat (4) @(negedge iclk);
    checks++;
    if (win_q.size() != 6) begin
      errors++; $display("FAIL gap_count: got %0d want 6", win_q.size());
    end
    for (int k = 0; k < exp_win.size(); k++) begin
      checks++;
      if (k >= win_q.size() || win_q[k] !== exp_win[k] || win_cyc[k] != exp_cyc[k]) begin
        errors++;
        $display("FAIL gap_win%0d: got %h @%0d want %h @%0d",
                 k, win_q[k], win_cyc[k], exp_win[k], exp_cyc[k]);
      end
    end
    checks++;
    if (bus.ovalid !== 1'b0 || bus.odata !== win_at(3, 4, 0)) begin
      errors++; $display("FAIL gap_hold: got v=%b %h want v=0 %h",
                         bus.ovalid, bus.odata, win_at(3, 4, 0));
    end
  endtask

  task automatic test_abort();
    do_reset();
    run_frame(5, 4, 0, 11, 1'b0);
    run_frame(5, 4, 128, BIG, 1'b0);
    repeat (4) @(negedge iclk);
    checks++;
    if (win_q.size() != 6) begin
      errors++; $display("FAIL abort_count: got %0d want 6", win_q.size());
    end
    for (int k = 0; k < exp_win.size(); k++) begin
      checks++;
      if (k >= win_q.size() || win_q[k] !== exp_win[k] || win_cyc[k] != exp_cyc[k]) begin
        errors++;
        $display("FAIL abort_win%0d: got %h @%0d want %h @%0d",
                 k, win_q[k], win_cyc[k], exp_win[k], exp_cyc[k]);
      end
    end
`ifdef WINGEN_LINE_ERR_EN
    checks++;
    if (err !== 1'b1) begin
      errors++; $display("FAIL abort_err: got %b want 1", err);
    end
`endif
  endtask

  task automatic test_reset_mid();
    do_reset();
    run_frame(5, 4, 0, 14, 1'b0);
    checks++;
    if (bus.ovalid !== 1'b1) begin
      errors++; $display("FAIL midrst_pre: got ovalid=%b want 1", bus.ovalid);
    end
    #2 reset_an_i = 1'b0;
    #1;
    checks++;
    if (bus.ovalid !== 1'b0 || bus.osync !== 1'b0) begin
      errors++; $display("FAIL midrst_ctl: got v=%b s=%b want 0 0", bus.ovalid, bus.osync);
    end
    checks++;
    if (bus.odata !== '0) begin
      errors++; $display("FAIL midrst_odata: got %h want 0", bus.odata);
    end
    clear_q();
    @(negedge iclk);
    reset_an_i = 1'b1;
`ifdef WINGEN_LINE_ERR_EN
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL midrst_err: got %b want 0", err);
    end
`endif
    for (int k = 0; k < 12; k++) begin
      bus.ivalid = 1'b1;
      bus.idata = DW'(k + 200);
      @(negedge iclk);
    end
    bus.ivalid = 1'b0;
    repeat (4) @(negedge iclk);
    checks++;
    if (win_q.size() != 0 || sync_cyc.size() != 0) begin
      errors++; $display("FAIL midrst_idle: got win=%0d sync=%0d want 0 0",
                         win_q.size(), sync_cyc.size());
    end
    run_frame(5, 4, 64, BIG, 1'b0);
    repeat (4) @(negedge iclk);
    checks++;
    if (win_q.size() != 6) begin
      errors++; $display("FAIL midrst_count: got %0d want 6", win_q.size());
    end
    for (int k = 0; k < exp_win.size(); k++) begin
      checks++;
      if (k >= win_q.size() || win_q[k] !== exp_win[k] || win_cyc[k] != exp_cyc[k]) begin
        errors++;
        $display("FAIL midrst_win%0d: got %h @%0d want %h @%0d",
                 k, win_q[k], win_cyc[k], exp_win[k], exp_cyc[k]);
      end
    end
  endtask

  task automatic test_max_width();
    int n;
    do_reset();
    run_frame(MW, 3, 0, BIG, 1'b0);
    repeat (4) @(negedge iclk);
    n = win_q.size();
    checks++;
    if (n != MW - 2) begin
      errors++; $display("FAIL maxw_count: got %0d want %0d", n, MW - 2);
    end
    for (int k = 0; k < exp_win.size(); k++) begin
      checks++;
      if (k >= n || win_q[k] !== exp_win[k] || win_cyc[k] != exp_cyc[k]) begin
        errors++;
        $display("FAIL maxw_win%0d: got %h @%0d want %h @%0d",
                 k, win_q[k], win_cyc[k], exp_win[k], exp_cyc[k]);
      end
    end
    checks++;
    if (n < 1 || win_q[n-1][TAP_CENTER*DW +: DW] !== 8'd14) begin
      errors++; $display("FAIL maxw_centre: got %h want 0e",
                         win_q[n-1][TAP_CENTER*DW +: DW]);
    end
    checks++;
    if (dut.u_core.state_q !== IDLE) begin
      errors++; $display("FAIL maxw_state: got %0d want IDLE", dut.u_core.state_q);
    end
  endtask

  task automatic test_extra();
    do_reset();
    run_frame(5, 4, 0, BIG, 1'b0);
    repeat (4) @(negedge iclk);
`ifdef WINGEN_LINE_ERR_EN
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL extra_err_pre: got %b want 0", err);
    end
`endif
    win_q.delete();
    win_cyc.delete();
    for (int k = 0; k < 6; k++) begin
      bus.ivalid = 1'b1;
      bus.idata = DW'(k + 90);
      @(negedge iclk);
    end
    bus.ivalid = 1'b0;
    repeat (4) @(negedge iclk);
    checks++;
    if (win_q.size() != 0) begin
      errors++; $display("FAIL extra_ovalid: got %0d windows want 0", win_q.size());
    end
    checks++;
    if (dut.u_core.state_q !== IDLE) begin
      errors++; $display("FAIL extra_state: got %0d want IDLE", dut.u_core.state_q);
    end
`ifdef WINGEN_LINE_ERR_EN
    checks++;
    if (err !== 1'b1) begin
      errors++; $display("FAIL extra_err: got %b want 1", err);
    end
`endif
  endtask

  initial begin
    reset_an_i = 1'b0;
    bus.isync = 1'b0;
    bus.ivalid = 1'b0;
    bus.idata = '0;
    cfg_width = '0;
    cfg_height = '0;
    test_reset();
    test_continuous();
    test_gap();
    test_abort();
    test_reset_mid();
    test_max_width();
    test_extra();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
